// File: rtl/seq0110_frame_tx.sv
// -----------------------------------------------------------------------------
// seq0110_frame_tx
//
// Serial frame transmitter for the 0110 sync-pattern link. A parallel word is
// accepted with a valid/ready handshake and then sent one bit per clock on
// `out`. Each frame is the 4-bit sync header 0,1,1,0, then the payload MSB
// first, then GAP_CYCLES forced idle-1 cycles. The line idles at 1.
//
// Handshake: a word is accepted on a rising clk edge where tx_valid=1 and
// tx_ready=1. tx_ready is high only in IDLE, so tx_valid seen while busy is
// ignored and nothing is queued. tx_data is sampled only at acceptance.
//
// Optional build macro: SEQ0110_FRAME_TX_PARITY_EN
//   When defined, a PARITY state sits between DATA and GAP. It sends one
//   even-parity bit, the XOR of all payload bits. When not defined, DATA goes
//   straight to GAP and no parity logic exists.
//
// Parameters:
//   DATA_W     payload width in bits (1..32)
//   GAP_CYCLES forced idle-1 cycles after each frame (0..15)
//
// Ports:
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   tx_valid  in   producer has a word
//   tx_data   in   payload word [DATA_W-1:0]
//   tx_ready  out  high exactly when in IDLE
//   out       out  registered serial line, idle level 1
//   busy      out  high in every state except IDLE
//   done      out  one-cycle registered pulse in the first IDLE cycle
//                  after a frame completes
// -----------------------------------------------------------------------------
module seq0110_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    // Element k of this vector is the line level in sync cycle k.
    localparam logic [3:0] SYNC_PAT = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [1:0]        sync_cnt, sync_next;
    logic [BIT_W-1:0]  bit_cnt, bit_next;
    logic [GAP_W-1:0]  gap_cnt, gap_next;
    logic [DATA_W-1:0] shift_q, shift_next;
    logic              out_next;
    logic              done_next;
    logic [1:0]        sync_inc;

`ifdef SEQ0110_FRAME_TX_PARITY_EN
    logic              parity_q, parity_next;
`endif

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign sync_inc = sync_cnt + 2'd1;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            sync_cnt <= 2'd0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            shift_q  <= '0;
            out      <= 1'b1;
            done     <= 1'b0;
`ifdef SEQ0110_FRAME_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            sync_cnt <= sync_next;
            bit_cnt  <= bit_next;
            gap_cnt  <= gap_next;
            shift_q  <= shift_next;
            out      <= out_next;
            done     <= done_next;
`ifdef SEQ0110_FRAME_TX_PARITY_EN
            parity_q <= parity_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. `out` is registered, so out_next is
    // the level the line shows during the cycle after this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        sync_next   = sync_cnt;
        bit_next    = bit_cnt;
        gap_next    = gap_cnt;
        shift_next  = shift_q;
        out_next    = 1'b1;
        done_next   = 1'b0;
`ifdef SEQ0110_FRAME_TX_PARITY_EN
        parity_next = parity_q;
`endif

        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_next  = ST_SYNC;
                    shift_next  = tx_data;
                    sync_next   = 2'd0;
                    out_next    = SYNC_PAT[0];
`ifdef SEQ0110_FRAME_TX_PARITY_EN
                    parity_next = ^tx_data;
`endif
                end
            end

            ST_SYNC: begin
                if (sync_cnt == 2'd3) begin
                    // Last sync cycle: present the payload MSB next.
                    state_next = ST_DATA;
                    bit_next   = '0;
                    out_next   = shift_q[DATA_W-1];
                    shift_next = shift_q << 1;
                end else begin
                    sync_next = sync_inc;
                    out_next  = SYNC_PAT[sync_inc];
                end
            end

            ST_DATA: begin
                if (bit_cnt == BIT_LAST) begin
`ifdef SEQ0110_FRAME_TX_PARITY_EN
                    state_next = ST_PARITY;
                    out_next   = parity_q;
`else
                    if (GAP_CYCLES > 0) begin
                        state_next = ST_GAP;
                        gap_next   = '0;
                    end else begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                    out_next = 1'b1;
`endif
                end else begin
                    bit_next   = bit_cnt + BIT_W'(1);
                    out_next   = shift_q[DATA_W-1];
                    shift_next = shift_q << 1;
                end
            end

`ifdef SEQ0110_FRAME_TX_PARITY_EN
            ST_PARITY: begin
                if (GAP_CYCLES > 0) begin
                    state_next = ST_GAP;
                    gap_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
                out_next = 1'b1;
            end
`endif

            ST_GAP: begin
                out_next = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    gap_next = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                // Unreachable encodings recover to an idle line.
                state_next = ST_IDLE;
                out_next   = 1'b1;
            end
        endcase
    end

endmodule
